// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_pkg
//  Purpose  : Shared core definitions for the RV32M multiply/divide unit:
//             M-extension opcode constants, FSM state type, decoder flag
//             carried into EX, and operand-signedness helpers.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

  // funct7 value that selects the M extension in OP-class instructions
  localparam logic [6:0] FUNCT7_M = 7'h01;

  // funct3 encodings of the eight M-extension operations
  localparam logic [2:0] FUNCT3_M_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_M_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_M_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_M_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_M_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_M_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_M_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_M_REMU   = 3'd7;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

  // ID/EX pipeline payload; is_mul_div steers the op to this unit
  typedef struct packed {
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_mul_div;
  } id_ex_data_t;

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
  function automatic logic op_a_is_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_M_MULH)   || (funct3 == FUNCT3_M_MULHSU) ||
           (funct3 == FUNCT3_M_DIV)    || (funct3 == FUNCT3_M_REM);
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM
  function automatic logic op_b_is_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_M_MULH) || (funct3 == FUNCT3_M_DIV) ||
           (funct3 == FUNCT3_M_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide unit. One radix-2 step per
//             cycle on operand magnitudes using a single shared 2W+1-bit
//             shift/accumulate register; signs are re-applied at the end.
//             Divide-by-zero and signed overflow finish in one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_e        state_q,  state_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [AW-1:0]        acc_q,    acc_d;     // mul: {carry, hi, lo}; div: {-, rem, quo}
  logic [W-1:0]         mag_b_q,  mag_b_d;   // multiplicand / divisor magnitude
  logic [2:0]           funct3_q, funct3_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [W-1:0]         res_q,    res_d;     // result of the op being presented
  logic [W-1:0]         result_q, result_d;  // last result actually delivered

  // Incoming operand decode: signs, magnitudes and early-exit results
  logic         in_sign_a, in_sign_b;
  logic         in_div_zero, in_overflow, in_special;
  logic [W-1:0] in_mag_a, in_mag_b, in_special_res;

  // Classify the request and form magnitudes at acceptance
  always_comb begin
    in_sign_a   = op_a_is_signed(funct3_i) & op_a_i[W-1];
    in_sign_b   = op_b_is_signed(funct3_i) & op_b_i[W-1];
    in_mag_a    = in_sign_a ? -op_a_i : op_a_i;
    in_mag_b    = in_sign_b ? -op_b_i : op_b_i;
    in_div_zero = funct3_i[2] && (op_b_i == '0);
    // funct3[0] clear on a divide op means signed (DIV/REM)
    in_overflow = funct3_i[2] && !funct3_i[0] &&
                  (op_a_i == MIN_INT) && (op_b_i == '1);
    in_special  = in_div_zero || in_overflow;
    // funct3[1] set on a divide op selects the remainder flavour
    if (in_div_zero) begin
      in_special_res = funct3_i[1] ? op_a_i : '1;
    end else begin
      in_special_res = funct3_i[1] ? '0 : MIN_INT;
    end
  end

  // One iteration of shift-add multiply or restoring divide
  logic [W:0]    mul_sum, div_trial;
  logic [AW-1:0] mul_next, div_shift, div_next, acc_step;

  // Compute the next accumulator value for the latched op
  always_comb begin
    mul_sum   = acc_q[AW-1:W] + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    mul_next  = {1'b0, mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[AW-2:0], 1'b0};
    div_trial = div_shift[AW-1:W] - {1'b0, mag_b_q};
    // A borrow out means the divisor did not fit: keep the shifted value
    div_next  = div_trial[W] ? div_shift : {div_trial, div_shift[W-1:1], 1'b1};
    acc_step  = funct3_q[2] ? div_next : mul_next;
  end

  // Final signed result from the accumulator after the last step
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, final_res;

  // Re-apply signs and select the requested slice
  always_comb begin
    prod = acc_step[2*W-1:0];
    if (sign_a_q ^ sign_b_q) prod = -prod;
    quo = acc_step[W-1:0];
    if (sign_a_q ^ sign_b_q) quo = -quo;
    rem = acc_step[2*W-1:W];
    if (sign_a_q) rem = -rem;
    case (funct3_q)
      FUNCT3_M_MUL:                                     final_res = prod[W-1:0];
      FUNCT3_M_MULH, FUNCT3_M_MULHSU, FUNCT3_M_MULHU:   final_res = prod[2*W-1:W];
      FUNCT3_M_DIV, FUNCT3_M_DIVU:                      final_res = quo;
      default:                                          final_res = rem;
    endcase
  end

  // Next-state, counter and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_b_d  = mag_b_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    res_d    = res_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          funct3_d = funct3_i;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          mag_b_d  = in_mag_b;
          acc_d    = {{(W+1){1'b0}}, in_mag_a};
          cnt_d    = CNT_WIDTH'(DATA_WIDTH);
          if (in_special) begin
            res_d   = in_special_res;
            state_d = MD_DONE;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            res_d   = final_res;
            state_d = MD_DONE;
          end
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        // A flushed result is never committed as the held value
        if (!flush_i) result_d = res_q;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_b_q  <= '0;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      res_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_b_q  <= mag_b_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      res_q    <= res_d;
      result_q <= result_d;
    end
  end

  // The new result is visible during DONE unless that cycle is flushed
  always_comb begin
    busy_o   = (state_q != MD_IDLE);
    valid_o  = (state_q == MD_DONE) && !flush_i;
    result_o = valid_o ? res_q : result_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Scoreboard bench for muldiv_unit (W = 32). Stimulus pushes the
//             expected result and latency; a monitor pops on valid_o.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT_NORMAL = W + 1;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
                         OP_MULHU = 3'd3, OP_DIV = 3'd4, OP_DIVU = 3'd5,
                         OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [2:0]   funct3_i = '0;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic         busy_o, valid_o;
  logic [W-1:0] result_o;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           issue_cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         rst_at_edge = 1'b1;
  logic [W-1:0] last_res = '0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Reference model straight from the RV32M definitions
  function automatic logic [W-1:0] ref_model(input logic [2:0] f3,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f3)
      OP_MUL:    begin p = sa * sb;            return p[31:0];  end
      OP_MULH:   begin p = sa * sb;            return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub);  return p[63:32]; end
      OP_MULHU:  begin p = ua * ub;            return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == MIN_INT && b == '1) return MIN_INT;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == '1) return '0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == OP_DIV || f3 == OP_REM) && a == MIN_INT && b == '1) return 1;
    return LAT_NORMAL;
  endfunction

  // Monitor: pop on every valid_o, otherwise the result must hold
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) last_res = '0;
    if (valid_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got valid_o with result %h, required no strobe", result_o);
      end else begin
        e = sb_q.pop_front();
        if (result_o !== e.res) begin
          errors++;
          $display("FAIL result: got %h, required %h", result_o, e.res);
        end
        checks++;
        if (cyc - e.issue_cyc != e.lat) begin
          errors++;
          $display("FAIL latency: got %0d, required %0d", cyc - e.issue_cyc, e.lat);
        end
        last_res = e.res;
      end
    end else begin
      checks++;
      if (result_o !== last_res) begin
        errors++;
        $display("FAIL result_hold: got %h, required %h", result_o, last_res);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Drive one start pulse; returns at the negedge of cycle 1
  task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input int lat, input bit track);
    exp_t e;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    if (track) begin
      e.res = exp_res; e.lat = lat; e.issue_cyc = cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic issue_rand(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(f3, a, b, ref_model(f3, a, b), ref_latency(f3, a, b), 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy_o}, '0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   f3;
    int           n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, busy_o},  '0);
    check("reset_valid",  {31'd0, valid_o}, '0);
    check("reset_result", result_o,         '0);
    rst = 1'b0;

    // MUL with busy/valid cycle-exact profile
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORMAL, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      check($sformatf("busy_cycle%0d", k),  {31'd0, busy_o},  {31'd0, (k <= 33)});
      check($sformatf("valid_cycle%0d", k), {31'd0, valid_o}, {31'd0, (k == 33)});
      @(negedge clk);
    end
    wait_idle();

    // Directed high-multiply and divide cases
    issue(OP_MULH,   MIN_INT,      MIN_INT,      32'h4000_0000, LAT_NORMAL, 1'b1); wait_idle();
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORMAL, 1'b1); wait_idle();
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NORMAL, 1'b1); wait_idle();
    issue(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORMAL, 1'b1); wait_idle();
    issue(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORMAL, 1'b1); wait_idle();
    issue(OP_DIVU,   32'd100,       32'd7,         32'h0000_000E, LAT_NORMAL, 1'b1); wait_idle();
    issue(OP_REMU,   32'd100,       32'd7,         32'h0000_0002, LAT_NORMAL, 1'b1); wait_idle();

    // Special cases complete in one cycle
    issue(OP_DIV,  32'd5,   32'd0,        32'hFFFF_FFFF, 1, 1'b1); wait_idle();
    issue(OP_REMU, 32'd5,   32'd0,        32'd5,         1, 1'b1); wait_idle();
    issue(OP_DIV,  MIN_INT, 32'hFFFF_FFFF, MIN_INT,      1, 1'b1); wait_idle();
    issue(OP_REM,  MIN_INT, 32'hFFFF_FFFF, 32'd0,        1, 1'b1); wait_idle();

    // Flush in CALC with an ignored start in the middle
    issue(OP_DIVU, 32'd100, 32'd7, '0, LAT_NORMAL, 1'b0);
    repeat (4) @(negedge clk);
    start_i = 1'b1; funct3_i = OP_MUL; op_a_i = 32'd9; op_b_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy",   {31'd0, busy_o},  '0);
    check("flush_valid",  {31'd0, valid_o}, '0);
    check("flush_result", result_o,         last_res);

    // Flush together with start in IDLE: nothing accepted
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = OP_MUL; op_a_i = 32'd2; op_b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_busy", {31'd0, busy_o}, '0);

    // Start while busy is dropped; the original op completes normally
    issue(OP_MUL, 32'd3, 32'd4, 32'h0000_000C, LAT_NORMAL, 1'b1);
    repeat (9) @(negedge clk);
    start_i = 1'b1; funct3_i = OP_MULHU; op_a_i = $urandom; op_b_i = $urandom;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();

    // Reset in the middle of CALC
    issue(OP_DIV, 32'd1000, 32'd3, '0, LAT_NORMAL, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",   {31'd0, busy_o},  '0);
    check("midrst_valid",  {31'd0, valid_o}, '0);
    check("midrst_result", result_o,         '0);
    rst = 1'b0;
    issue(OP_DIV, 32'd20, 32'd3, 32'd6, LAT_NORMAL, 1'b1);
    wait_idle();

    // Randomised operations biased toward corner operands
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MIN_INT; b = '1; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: begin a = -32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        4: b = '1;
        default: ;
      endcase
      issue_rand(f3, a, b);
      wait_idle();
    end

    // Drain the scoreboard
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", 32'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit, parametrised in operand width. It sits beside the ALU in the EX stage.
- Accepts one operation per start pulse and holds busy_o while computing; the hazard logic uses busy_o to stall IF/ID/EX.
- Returns the result with a one-cycle valid_o pulse.
- Covers all eight M-extension ops (funct7 = 7'h01) with spec-exact divide-by-zero and overflow results.

Parameters:
- DATA_WIDTH, 32, operand/result width W; must be even and >= 8.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; accepted only in IDLE.
- funct3_i  in  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a_i  in  W  rs1 operand (forwarded value).
- op_b_i  in  W  rs2 operand (forwarded value).
- flush_i  in  1  abort the in-flight op (branch or jump redirect).
- busy_o  out  1  high from the cycle after acceptance until DONE is left.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  W  result; held stable until the next accepted start.

Behaviour:
Reset and state machine:
- Reset: state IDLE; busy_o, valid_o, result_o, counter and datapath registers all 0. Reset overrides every other input and applies mid-operation.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start_i && !flush_i when the op is not a special case. Operands, funct3 and sign flags are latched at that edge; the counter loads W.
- IDLE -> DONE on start_i for the special cases: divisor == 0, or signed overflow (DIV/REM with a = MIN_INT, b = -1).
- CALC: one radix-2 step per cycle, counter decrements; when the counter reaches 1, go to DONE.
- DONE: valid_o = 1 and result_o updated in that same cycle; next state IDLE.

Latency and handshake:
- Normal op: start sampled at edge 0, valid_o high in cycle W+1, busy_o high in cycles 1..W+1. For W = 32, result 33 cycles after start.
- Special case: valid_o in cycle 1.
- start_i while busy_o is ignored and not queued.

Flush:
- flush_i in CALC or DONE forces IDLE at the next edge; valid_o stays 0 and result_o keeps its old value.
- flush_i together with start_i in IDLE: flush wins, nothing accepted.

Arithmetic:
- Multiply uses unsigned shift-add on magnitudes into a 2W-bit accumulator.
  - Magnitude source is signed for MULH (a, b) and MULHSU (a only); MUL and MULHU are unsigned.
  - The product is negated when the operand sign flags differ.
  - MUL returns the low W bits; MULH/MULHSU/MULHU return the high W bits.
- Divide uses restoring shift-subtract on magnitudes.
  - DIV/REM use signed magnitudes.
  - Quotient sign = sa ^ sb; remainder sign = sa.
- Special results:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give op_a_i.
  - Overflow: DIV gives MIN_INT; REM gives 0.
- No exceptions are raised.

Decomposition:
Additions to the shared core package:
- FUNCT7_M = 7'h01.
- FUNCT3_M_MUL..FUNCT3_M_REMU localparams (values 0-7).
- muldiv_state_e enum {MD_IDLE, MD_CALC, MD_DONE}, 2 bits.
- Decoder-side flag IsMulDiv, added to id_ex_data_t.

Sub-modules:
- No sub-module: the FSM, counter, and one shared 2W+1-bit shift/accumulate register serve both mul and div, so no split is natural.

Test Plan:
1. W = 32, MUL 7 * 0xFFFFFFFD (-3) -> result 0xFFFFFFEB. busy_o high cycles 1..33; valid_o pulse exactly in cycle 33.
2. MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 0xE. REMU 100 / 7 -> 2.
4. Special cases, each with valid_o in cycle 1:
   - DIV 5 / 0 -> 0xFFFFFFFF.
   - REMU 5 / 0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
   - REM same operands -> 0.
5. Flush and start-while-busy:
   - Start DIVU 100 / 7, assert flush_i in cycle 10 -> IDLE at cycle 11, no valid_o, result_o unchanged.
   - A second start_i pulsed during CALC -> ignored.
   - New start MUL 3 * 4 -> 0xC after 33 cycles.
6. rst asserted in cycle 15 of CALC -> at the next edge all outputs are 0 and the state is IDLE. Deassert and start DIV 20 / 3 -> 6.
